// File: rtl/proc_isa_pkg.sv
// ISA constants shared by the multi-cycle sequencer and its decoder:
// opcodes, field positions, FSM state codes and datapath mux encodings.
package proc_isa_pkg;

    localparam logic [3:0] OP_ALU_R  = 4'b0000;
    localparam logic [3:0] OP_CMP_R  = 4'b0010;
    localparam logic [3:0] OP_SW     = 4'b0101;
    localparam logic [3:0] OP_BRANCH = 4'b0110;
    localparam logic [3:0] OP_ALU_I  = 4'b1000;
    localparam logic [3:0] OP_LW     = 4'b1001;
    localparam logic [3:0] OP_CMP_I  = 4'b1010;
    localparam logic [3:0] OP_JAL    = 4'b1011;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 3;
    localparam int FN_LSB  = 4;
    localparam int FN_MSB  = 7;
    localparam int IMM_LSB = 8;
    localparam int IMM_MSB = 23;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 23;
    localparam int RS1_LSB = 24;
    localparam int RS1_MSB = 27;
    localparam int RD_LSB  = 28;
    localparam int RD_MSB  = 31;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_ALU    = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MDR = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_CMP,
        CL_LW,
        CL_SW,
        CL_BRANCH,
        CL_JAL,
        CL_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/mc_proc_sequencer_if.sv
// Shared instruction/data memory port with a ready handshake.
interface mc_proc_sequencer_if;

    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/proc_decode.sv
// Combinational instruction decoder: IR to instruction class, ALU controls
// and register-file indices.
module proc_decode
    import proc_isa_pkg::*;
(
    input  logic [31:0]  ir,
    output instr_class_t iclass,
    output logic [4:0]   alu_fn,
    output logic         alu_src2_sel,
    output logic [3:0]   rd_index0,
    output logic [3:0]   rd_index1,
    output logic [3:0]   wrt_index,
    output logic [15:0]  imm
);

    logic [3:0] fn;

    assign fn        = ir[FN_MSB:FN_LSB];
    assign wrt_index = ir[RD_MSB:RD_LSB];
    assign imm       = ir[IMM_MSB:IMM_LSB];

    always_comb begin
        iclass       = CL_ILLEGAL;
        alu_fn       = {1'b0, fn};
        alu_src2_sel = 1'b0;
        rd_index0    = ir[RS1_MSB:RS1_LSB];
        rd_index1    = ir[RS2_MSB:RS2_LSB];
        case (ir[OPC_MSB:OPC_LSB])
            OP_ALU_R: iclass = CL_ALU;
            OP_ALU_I: begin
                iclass       = CL_ALU;
                alu_src2_sel = 1'b1;
            end
            OP_CMP_R: begin
                iclass = CL_CMP;
                alu_fn = {1'b1, fn};
            end
            OP_CMP_I: begin
                iclass       = CL_CMP;
                alu_fn       = {1'b1, fn};
                alu_src2_sel = 1'b1;
            end
            OP_LW: begin
                iclass       = CL_LW;
                alu_src2_sel = 1'b1;
            end
            // SW and BRANCH read the rd and rs1 slots (store data / compare operands)
            OP_SW: begin
                iclass       = CL_SW;
                alu_src2_sel = 1'b1;
                rd_index0    = ir[RD_MSB:RD_LSB];
                rd_index1    = ir[RS1_MSB:RS1_LSB];
            end
            OP_BRANCH: begin
                iclass       = CL_BRANCH;
                alu_fn       = {1'b1, fn};
                alu_src2_sel = 1'b1;
                rd_index0    = ir[RD_MSB:RD_LSB];
                rd_index1    = ir[RS1_MSB:RS1_LSB];
            end
            OP_JAL: begin
                iclass       = CL_JAL;
                alu_src2_sel = 1'b1;
            end
            default: iclass = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_proc_sequencer.sv
// Multi-cycle control sequencer owning IR, MDR, the retire counter and the FSM.
// Build option SEQ_ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state instead of a NOP.
module mc_proc_sequencer
    import proc_isa_pkg::*;
#(
    parameter logic RESET_PC_SEL = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mc_proc_sequencer_if.master        mem,
    input  logic                       aluCompTrue,
    output logic                       pcWrtEn,
    output logic [1:0]                 pcSrc,
    output logic                       pc_rst_sel,
    output logic [4:0]                 aluFn,
    output logic                       aluSrc2Sel,
    output logic [3:0]                 rdIndex0,
    output logic [3:0]                 rdIndex1,
    output logic [3:0]                 wrtIndex,
    output logic [15:0]                imm,
    output logic                       regFileWrtEn,
    output logic [1:0]                 regFileWrtSel,
    output logic [31:0]                mdr,
    output logic                       retire,
    output logic [31:0]                instret,
    output logic                       trap
);

    logic [2:0]   state;
    logic [2:0]   state_next;
    logic [31:0]  ir;
    logic         req_int;
    instr_class_t iclass;

    proc_decode u_decode (
        .ir           (ir),
        .iclass       (iclass),
        .alu_fn       (aluFn),
        .alu_src2_sel (aluSrc2Sel),
        .rd_index0    (rdIndex0),
        .rd_index1    (rdIndex1),
        .wrt_index    (wrtIndex),
        .imm          (imm)
    );

    assign pc_rst_sel = RESET_PC_SEL;
    // Reset lands in FETCH, so the request is gated to drop during reset without waiting for a clock
    assign mem.mem_req = req_int & rst_n;

    always_comb begin
        state_next       = state;
        req_int          = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        pcWrtEn          = 1'b0;
        pcSrc            = PC_SRC_PLUS4;
        regFileWrtEn     = 1'b0;
        regFileWrtSel    = WB_SEL_ALU;
        retire           = 1'b0;
        case (state)
            ST_FETCH: begin
                req_int = 1'b1;
                if (mem.mem_ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (iclass == CL_ILLEGAL) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                    state_next = ST_TRAP;
`else
                    state_next = ST_WB;
`endif
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (iclass)
                    CL_LW, CL_SW: state_next = ST_MEM;
                    CL_BRANCH: begin
                        pcWrtEn    = 1'b1;
                        pcSrc      = aluCompTrue ? PC_SRC_BRANCH : PC_SRC_PLUS4;
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                    default: state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                req_int          = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = (iclass == CL_SW);
                if (mem.mem_ready) begin
                    if (iclass == CL_SW) begin
                        pcWrtEn    = 1'b1;
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                regFileWrtEn = (iclass != CL_ILLEGAL);
                pcWrtEn      = 1'b1;
                retire       = 1'b1;
                state_next   = ST_FETCH;
                case (iclass)
                    CL_LW:  regFileWrtSel = WB_SEL_MDR;
                    CL_JAL: begin
                        regFileWrtSel = WB_SEL_PC4;
                        pcSrc         = PC_SRC_ALU;
                    end
                    default: regFileWrtSel = WB_SEL_ALU;
                endcase
            end
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            ir      <= '0;
            mdr     <= '0;
            instret <= '0;
        end else begin
            state <= state_next;
            if (state == ST_FETCH && mem.mem_ready) ir <= mem.mem_rdata;
            if (state == ST_MEM && mem.mem_ready && iclass == CL_LW) mdr <= mem.mem_rdata;
            if (retire) instret <= instret + 32'd1;
        end
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trap_q <= 1'b0;
        else if (state_next == ST_TRAP) trap_q <= 1'b1;
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mc_proc_sequencer.sv
// Directed bench for mc_proc_sequencer: per-cycle control checks for each
// instruction class, wait states, mid-transaction reset and illegal opcodes.
module tb_mc_proc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        aluCompTrue;
    logic        pcWrtEn;
    logic [1:0]  pcSrc;
    logic        pc_rst_sel;
    logic [4:0]  aluFn;
    logic        aluSrc2Sel;
    logic [3:0]  rdIndex0;
    logic [3:0]  rdIndex1;
    logic [3:0]  wrtIndex;
    logic [15:0] imm;
    logic        regFileWrtEn;
    logic [1:0]  regFileWrtSel;
    logic [31:0] mdr;
    logic        retire;
    logic [31:0] instret;
    logic        trap;

    int n_assert = 0;
    int n_fail   = 0;

    mc_proc_sequencer_if bus ();

    mc_proc_sequencer #(.RESET_PC_SEL(1'b0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem           (bus),
        .aluCompTrue   (aluCompTrue),
        .pcWrtEn       (pcWrtEn),
        .pcSrc         (pcSrc),
        .pc_rst_sel    (pc_rst_sel),
        .aluFn         (aluFn),
        .aluSrc2Sel    (aluSrc2Sel),
        .rdIndex0      (rdIndex0),
        .rdIndex1      (rdIndex1),
        .wrtIndex      (wrtIndex),
        .imm           (imm),
        .regFileWrtEn  (regFileWrtEn),
        .regFileWrtSel (regFileWrtSel),
        .mdr           (mdr),
        .retire        (retire),
        .instret       (instret),
        .trap          (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs change on the falling edge, outputs checked 1ns later
    task automatic cyc(input logic ready, input logic [31:0] rdata, input logic comp);
        @(negedge clk);
        bus.mem_ready = ready;
        bus.mem_rdata = rdata;
        aluCompTrue   = comp;
        #1;
    endtask

    localparam logic [31:0] I_ADD  = 32'h3120_0000;
    localparam logic [31:0] I_LW   = 32'h5100_1009;
    localparam logic [31:0] I_BR   = 32'h7800_0416;
    localparam logic [31:0] I_JAL  = 32'h6600_080B;
    localparam logic [31:0] I_CMP  = 32'h2450_0032;
    localparam logic [31:0] I_SW   = 32'h9A00_0C05;
    localparam logic [31:0] I_ILL  = 32'h0000_000F;

    initial begin
        rst_n         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        aluCompTrue   = 1'b0;
        #1;
        chk("rst mem_req", bus.mem_req, 0);
        chk("rst retire", retire, 0);
        chk("rst instret", instret, 0);
        chk("rst trap", trap, 0);
        chk("rst pcWrtEn", pcWrtEn, 0);
        chk("rst rdIndex0", rdIndex0, 0);
        chk("rst imm", imm, 0);
        chk("rst mdr", mdr, 0);
        chk("rst pc_rst_sel", pc_rst_sel, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU-R add r3 = r1 + r2, zero wait
        cyc(1'b1, I_ADD, 1'b0);
        chk("add fetch req", bus.mem_req, 1);
        chk("add fetch addr_sel", bus.mem_addr_sel, 0);
        cyc(1'b0, '0, 1'b0);
        chk("add decode retire", retire, 0);
        chk("add rdIndex0", rdIndex0, 1);
        chk("add rdIndex1", rdIndex1, 2);
        cyc(1'b0, '0, 1'b0);
        chk("add exec retire", retire, 0);
        cyc(1'b0, '0, 1'b0);
        chk("add wb regWrtEn", regFileWrtEn, 1);
        chk("add wb wrtIndex", wrtIndex, 3);
        chk("add wb pcSrc", pcSrc, 0);
        chk("add wb pcWrtEn", pcWrtEn, 1);
        chk("add wb retire", retire, 1);
        chk("add wb instret", instret, 0);

        // LW with two MEM wait cycles
        cyc(1'b1, I_LW, 1'b0);
        chk("lw fetch req", bus.mem_req, 1);
        chk("add instret", instret, 1);
        chk("add retire drop", retire, 0);
        cyc(1'b0, '0, 1'b0);
        chk("lw aluSrc2Sel", aluSrc2Sel, 1);
        chk("lw imm", imm, 16'h0010);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, 32'h1111_1111, 1'b0);
        chk("lw mem req", bus.mem_req, 1);
        chk("lw mem addr_sel", bus.mem_addr_sel, 1);
        chk("lw mem we", bus.mem_we, 0);
        cyc(1'b0, '0, 1'b0);
        chk("lw wait mdr", mdr, 0);
        chk("lw wait retire", retire, 0);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("lw mem req ready", bus.mem_req, 1);
        cyc(1'b0, '0, 1'b0);
        chk("lw wb mdr", mdr, 32'hDEAD_BEEF);
        chk("lw wb wrtSel", regFileWrtSel, 1);
        chk("lw wb regWrtEn", regFileWrtEn, 1);
        chk("lw wb retire", retire, 1);
        chk("lw wb wrtIndex", wrtIndex, 5);

        // BRANCH taken
        cyc(1'b1, I_BR, 1'b0);
        chk("br1 fetch req", bus.mem_req, 1);
        chk("lw instret", instret, 2);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        chk("br1 pcWrtEn", pcWrtEn, 1);
        chk("br1 pcSrc", pcSrc, 1);
        chk("br1 retire", retire, 1);
        chk("br1 regWrtEn", regFileWrtEn, 0);
        chk("br1 rdIndex0", rdIndex0, 7);
        chk("br1 rdIndex1", rdIndex1, 8);
        chk("br1 aluFn", aluFn, 5'h11);
        chk("br1 aluSrc2Sel", aluSrc2Sel, 1);

        // BRANCH not taken
        cyc(1'b1, I_BR, 1'b1);
        chk("br0 fetch req", bus.mem_req, 1);
        chk("br1 instret", instret, 3);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
        chk("br0 pcWrtEn", pcWrtEn, 1);
        chk("br0 pcSrc", pcSrc, 0);
        chk("br0 retire", retire, 1);
        chk("br0 regWrtEn", regFileWrtEn, 0);

        // JAL with rd == rs1
        cyc(1'b1, I_JAL, 1'b0);
        chk("jal fetch req", bus.mem_req, 1);
        chk("br0 instret", instret, 4);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("jal exec retire", retire, 0);
        cyc(1'b0, '0, 1'b0);
        chk("jal wb regWrtEn", regFileWrtEn, 1);
        chk("jal wb wrtSel", regFileWrtSel, 2);
        chk("jal wb pcWrtEn", pcWrtEn, 1);
        chk("jal wb pcSrc", pcSrc, 2);
        chk("jal wb wrtIndex", wrtIndex, 6);
        chk("jal wb rdIndex0", rdIndex0, 6);
        chk("jal wb retire", retire, 1);

        // CMP-R with one FETCH wait cycle
        cyc(1'b0, '0, 1'b0);
        chk("cmp fetch wait req", bus.mem_req, 1);
        chk("jal instret", instret, 5);
        cyc(1'b1, I_CMP, 1'b0);
        chk("cmp fetch req", bus.mem_req, 1);
        cyc(1'b0, '0, 1'b0);
        chk("cmp aluFn", aluFn, 5'h13);
        chk("cmp aluSrc2Sel", aluSrc2Sel, 0);
        cyc(1'b0, '0, 1'b0);
        chk("cmp exec retire", retire, 0);
        cyc(1'b0, '0, 1'b0);
        chk("cmp wb retire", retire, 1);
        chk("cmp wb wrtSel", regFileWrtSel, 0);

        // SW zero wait
        cyc(1'b1, I_SW, 1'b0);
        chk("cmp instret", instret, 6);
        cyc(1'b0, '0, 1'b0);
        chk("sw rdIndex0", rdIndex0, 9);
        chk("sw rdIndex1", rdIndex1, 4'hA);
        cyc(1'b0, '0, 1'b0);
        chk("sw exec req", bus.mem_req, 0);
        cyc(1'b1, '0, 1'b0);
        chk("sw mem we", bus.mem_we, 1);
        chk("sw mem addr_sel", bus.mem_addr_sel, 1);
        chk("sw mem retire", retire, 1);
        chk("sw mem pcWrtEn", pcWrtEn, 1);
        chk("sw mem pcSrc", pcSrc, 0);
        chk("sw mem regWrtEn", regFileWrtEn, 0);

        // SW abandoned by reset during a MEM wait
        cyc(1'b1, I_SW, 1'b0);
        chk("sw instret", instret, 7);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("sw2 mem req", bus.mem_req, 1);
        chk("sw2 mem we", bus.mem_we, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("sw2 rst req", bus.mem_req, 0);
        chk("sw2 rst instret", instret, 0);
        chk("sw2 rst retire", retire, 0);
        chk("sw2 rst rdIndex0", rdIndex0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("sw2 post req", bus.mem_req, 1);
        chk("sw2 post addr_sel", bus.mem_addr_sel, 0);
        chk("sw2 post we", bus.mem_we, 0);

        // Illegal opcode 4'b1111
        cyc(1'b1, I_ILL, 1'b0);
        chk("ill fetch req", bus.mem_req, 1);
        cyc(1'b0, '0, 1'b0);
        chk("ill decode retire", retire, 0);
        cyc(1'b1, I_ADD, 1'b0);
`ifdef SEQ_ILLEGAL_TRAP_EN
        chk("ill trap", trap, 1);
        chk("ill trap req", bus.mem_req, 0);
        chk("ill trap retire", retire, 0);
        cyc(1'b1, I_ADD, 1'b0);
        cyc(1'b1, I_ADD, 1'b0);
        chk("ill trap sticky", trap, 1);
        chk("ill trap no fetch", bus.mem_req, 0);
        chk("ill trap instret", instret, 0);
`else
        chk("ill nop retire", retire, 1);
        chk("ill nop pcWrtEn", pcWrtEn, 1);
        chk("ill nop pcSrc", pcSrc, 0);
        chk("ill nop regWrtEn", regFileWrtEn, 0);
        chk("ill nop trap", trap, 0);
        cyc(1'b0, '0, 1'b0);
        chk("ill nop next req", bus.mem_req, 1);
        chk("ill nop instret", instret, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
